// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Fetch/data arbiter in front of a single-port unified memory: one outstanding
// transaction at a time, with DM priority, IF anti-starvation and a bus timeout.
module mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                owner_dm;
    logic [1:0]          dm_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                err;
    logic                lat_we;
    logic [31:0]         lat_addr;
    logic [31:0]         lat_wdata;

    logic grant;
    logic grant_if;
    logic busy;
    logic done;
    logic expired;

    assign busy     = (state == BUSY);
    assign done     = (state == DONE);
    assign grant    = if_req || dm_req;
    // IF takes the grant when alone, or once DM has won twice in a row over it
    assign grant_if = if_req && (!dm_req || (dm_cnt == 2'd2));
    assign expired  = busy && !mem_ack && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = BUSY;
            BUSY:    if (mem_ack || expired) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_dm <= 1'b0;
            dm_cnt   <= 2'd0;
            wait_cnt <= '0;
            err      <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            if (state == IDLE && grant) begin
                owner_dm <= !grant_if;
                wait_cnt <= '0;
                err      <= 1'b0;
                if (grant_if) begin
                    dm_cnt <= 2'd0;
                end else if (if_req && dm_cnt != 2'd2) begin
                    dm_cnt <= dm_cnt + 2'd1;
                end
            end else if (busy) begin
                if (mem_ack) begin
                    if (!lat_we) begin
                        if (owner_dm) dm_rdata <= mem_rdata;
                        else          if_rdata <= mem_rdata;
                    end
                end else if (expired) begin
                    err <= 1'b1;
                    if (owner_dm) dm_rdata <= '0;
                    else          if_rdata <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

    // Request payload is pure data; the outputs below are gated by BUSY
    always_ff @(posedge clk) begin
        if (state == IDLE && grant) begin
            lat_we    <= grant_if ? 1'b0 : dm_we;
            lat_addr  <= grant_if ? if_addr : dm_addr;
            lat_wdata <= grant_if ? 32'd0 : dm_wdata;
        end
    end

    assign mem_req   = busy;
    assign mem_we    = busy && lat_we;
    assign mem_addr  = busy ? lat_addr : 32'd0;
    assign mem_wdata = busy ? lat_wdata : 32'd0;
    assign if_ready  = done && !owner_dm;
    assign dm_ready  = done && owner_dm;
    assign bus_err   = done && err;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mem_arbiter: reset, fetch, priority rotation, store,
// timeout and reset during a transaction.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_dm_rdata;

    mem_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
        dm_addr = 0; dm_wdata = 0; mem_rdata = 0; mem_ack = 0;
        step(); step();
        checks++;
        if ({if_ready, dm_ready, mem_req, mem_we, bus_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=00000", {if_ready, dm_ready, mem_req, mem_we, bus_err});
        end
        checks++;
        if ({if_rdata, dm_rdata, mem_addr, mem_wdata} !== 128'd0) begin
            failures++;
            $display("FAIL reset_data if_rdata=%h dm_rdata=%h mem_addr=%h mem_wdata=%h want all 0",
                     if_rdata, dm_rdata, mem_addr, mem_wdata);
        end
        @(negedge clk);
        reset = 1'b1;
        step();
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req mem_req=%b want=0", mem_req);
        end
    endtask

    task automatic test_fetch();
        if_req = 1; if_addr = 32'h0000_0010; mem_ack = 1; mem_rdata = 32'h0050_0093;
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || if_ready !== 1'b0) begin
            failures++;
            $display("FAIL fetch_c1 req=%b addr=%h we=%b rdy=%b want 1/00000010/0/0",
                     mem_req, mem_addr, mem_we, if_ready);
        end
        step();
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h0050_0093 || dm_ready !== 1'b0 ||
            bus_err !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL fetch_c2 if_ready=%b if_rdata=%h dm_ready=%b bus_err=%b mem_req=%b want 1/00500093/0/0/0",
                     if_ready, if_rdata, dm_ready, bus_err, mem_req);
        end
        if_req = 0; mem_ack = 0;
        step();
        checks++;
        if (if_ready !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL fetch_c3 if_ready=%b mem_req=%b want 0/0", if_ready, mem_req);
        end
    endtask

    task automatic test_priority();
        logic [5:0] is_if;
        logic [31:0] exp_addr;
        is_if = 6'b100100;                      // grant order DM,DM,IF,DM,DM,IF (bit g)
        if_req = 1; if_addr = 32'h0000_0100;
        dm_req = 1; dm_we = 0; dm_addr = 32'h0000_0200; dm_wdata = 32'h0;
        mem_ack = 1;
        for (int g = 0; g < 6; g++) begin
            mem_rdata = 32'hA000_0000 + 32'(g);
            exp_addr = is_if[g] ? 32'h100 : 32'h200;
            step();
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_we !== 1'b0) begin
                failures++;
                $display("FAIL prio_grant%0d req=%b addr=%h we=%b want 1/%h/0", g, mem_req, mem_addr, mem_we, exp_addr);
            end
            step();
            checks++;
            if (if_ready !== is_if[g] || dm_ready !== !is_if[g] ||
                (is_if[g] ? if_rdata : dm_rdata) !== mem_rdata) begin
                failures++;
                $display("FAIL prio_ready%0d if_ready=%b dm_ready=%b if_rdata=%h dm_rdata=%h want if_ready=%b rdata=%h",
                         g, if_ready, dm_ready, if_rdata, dm_rdata, is_if[g], mem_rdata);
            end
            if (!is_if[g]) exp_dm_rdata = mem_rdata;
            step();
            checks++;
            if (if_ready !== 1'b0 || dm_ready !== 1'b0 || mem_req !== 1'b0) begin
                failures++;
                $display("FAIL prio_idle%0d if_ready=%b dm_ready=%b mem_req=%b want 0/0/0", g, if_ready, dm_ready, mem_req);
            end
        end
        if_req = 0; dm_req = 0; mem_ack = 0;
        step(); step(); step();
    endtask

    task automatic test_store();
        dm_req = 1; dm_we = 1; dm_addr = 32'h64; dm_wdata = 32'hDEAD_BEEF;
        mem_ack = 0; mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h64 ||
                mem_wdata !== 32'hDEAD_BEEF || dm_ready !== 1'b0) begin
                failures++;
                $display("FAIL store_busy%0d req=%b we=%b addr=%h wdata=%h rdy=%b want 1/1/00000064/deadbeef/0",
                         i, mem_req, mem_we, mem_addr, mem_wdata, dm_ready);
            end
            if (i == 3) mem_ack = 1;
        end
        step();
        checks++;
        if (dm_ready !== 1'b1 || bus_err !== 1'b0 || dm_rdata !== exp_dm_rdata ||
            mem_req !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL store_done dm_ready=%b bus_err=%b dm_rdata=%h mem_req=%b mem_we=%b want 1/0/%h/0/0",
                     dm_ready, bus_err, dm_rdata, mem_req, mem_we, exp_dm_rdata);
        end
        dm_req = 0; dm_we = 0; mem_ack = 0;
        step();
        checks++;
        if (dm_ready !== 1'b0) begin
            failures++;
            $display("FAIL store_pulse dm_ready=%b want 0", dm_ready);
        end
    endtask

    task automatic test_timeout();
        int busy_seen;
        busy_seen = 0;
        dm_req = 1; dm_we = 0; dm_addr = 32'h80; mem_ack = 0; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 16; i++) begin
            step();
            if (mem_req === 1'b1 && dm_ready === 1'b0) busy_seen++;
        end
        checks++;
        if (busy_seen != 16) begin
            failures++;
            $display("FAIL timeout_busy busy_cycles=%0d want 16", busy_seen);
        end
        step();
        checks++;
        if (mem_req !== 1'b0 || dm_ready !== 1'b1 || bus_err !== 1'b1 || dm_rdata !== 32'd0) begin
            failures++;
            $display("FAIL timeout_done mem_req=%b dm_ready=%b bus_err=%b dm_rdata=%h want 0/1/1/00000000",
                     mem_req, dm_ready, bus_err, dm_rdata);
        end
        dm_req = 0;
        step();
        checks++;
        if (bus_err !== 1'b0 || dm_ready !== 1'b0) begin
            failures++;
            $display("FAIL timeout_after bus_err=%b dm_ready=%b want 0/0", bus_err, dm_ready);
        end
    endtask

    task automatic test_reset_mid();
        int rdy_seen;
        rdy_seen = 0;
        if_req = 1; if_addr = 32'h20; mem_ack = 0; mem_rdata = 32'h0000_0013;
        step(); step();
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_busy mem_req=%b want 1", mem_req);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'd0 || if_ready !== 1'b0 || bus_err !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async mem_req=%b mem_addr=%h if_ready=%b bus_err=%b want 0/0/0/0",
                     mem_req, mem_addr, if_ready, bus_err);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (if_ready === 1'b1 || mem_req === 1'b1) rdy_seen++;
        end
        @(negedge clk);
        reset = 1'b1;
        mem_ack = 1;
        step();
        checks++;
        if (rdy_seen != 0 || mem_req !== 1'b1 || mem_addr !== 32'h20) begin
            failures++;
            $display("FAIL rstmid_resume activity_in_reset=%0d mem_req=%b mem_addr=%h want 0/1/00000020",
                     rdy_seen, mem_req, mem_addr);
        end
        step();
        checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h0000_0013 || bus_err !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_done if_ready=%b if_rdata=%h bus_err=%b want 1/00000013/0",
                     if_ready, if_rdata, bus_err);
        end
        if_req = 0; mem_ack = 0;
        step();
    endtask

    initial begin
        exp_dm_rdata = 32'd0;
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the number of BUSY cycles without mem_ack before a transaction is aborted.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  fetch-stage request; held high with if_addr stable until if_ready.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_rdata  output  32  fetched instruction, valid while if_ready=1.
REQ-007 if_ready  output  1  one-cycle completion pulse for fetch.
REQ-008 dm_req  input  1  memory-stage request; held high with dm_we, dm_addr and dm_wdata stable until dm_ready.
REQ-009 dm_we  input  1  1=write, 0=read.
REQ-010 dm_addr  input  32  data byte address.
REQ-011 dm_wdata  input  32  store data.
REQ-012 dm_rdata  output  32  load data, valid while dm_ready=1.
REQ-013 dm_ready  output  1  one-cycle completion pulse for data access.
REQ-014 mem_req  output  1  request to single-port unified memory.
REQ-015 mem_we  output  1  memory write enable.
REQ-016 mem_addr  output  32  memory address.
REQ-017 mem_wdata  output  32  memory write data.
REQ-018 mem_rdata  input  32  memory read data, valid when mem_ack=1.
REQ-019 mem_ack  input  1  memory completion, sampled only while mem_req=1.
REQ-020 bus_err  output  1  pulses together with the ready pulse when the transaction timed out.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-022 IDLE: when any request is high, the FSM SHALL latch owner, we, addr and wdata at the edge and move to BUSY; with no request it SHALL stay in IDLE.
REQ-023 Priority: dm_req SHALL win over if_req, except after 2 consecutive DM grants while if_req was pending, when IF SHALL win the next grant.
REQ-024 The consecutive-DM counter SHALL clear on any IF grant and SHALL saturate at 2.
REQ-025 In BUSY, mem_req SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL come from the latched registers; in IDLE and DONE, mem_req and mem_we SHALL be 0.
REQ-026 A fetch grant SHALL always drive mem_we=0.
REQ-027 BUSY with mem_ack=1: the FSM SHALL capture mem_rdata into the owner's rdata register (reads only) and move to DONE.
REQ-028 On a DM write, dm_rdata SHALL hold its previous value.
REQ-029 In BUSY, a wait counter SHALL increment each cycle without mem_ack and SHALL reset to 0 on entering BUSY.
REQ-030 When the wait counter reaches TIMEOUT-1 without mem_ack, the FSM SHALL move to DONE with bus_err set and the owner's rdata set to 0.
REQ-031 In DONE, the owner's ready SHALL be 1 for exactly that cycle, bus_err SHALL be 1 only for timeout, and the FSM SHALL return to IDLE at the next edge.
REQ-032 Requests present during BUSY or DONE SHALL be ignored; they are evaluated only in IDLE.
REQ-033 Minimum latency SHALL be: req in cycle 0, mem_req and ack in cycle 1, ready in cycle 2, next grant in cycle 3.
REQ-034 mem_ack arriving while not in BUSY SHALL be ignored.
REQ-035 if_ready and dm_ready SHALL never be 1 in the same cycle.

Reset
REQ-036 While reset=0, state SHALL be IDLE and all outputs 0 (if_rdata, dm_rdata, ready, mem_*, bus_err), asynchronously, including in the middle of a BUSY transaction.
REQ-037 Any transaction interrupted by reset SHALL be abandoned with no ready pulse; operation SHALL resume from IDLE on the first edge after reset=1.

Verification
REQ-038 Fetch: if_req=1, if_addr=0x0000_0010, mem_ack the same cycle with mem_rdata=0x0050_0093 -> mem_addr=0x10 and mem_we=0 in cycle 1; if_ready=1 and if_rdata=0x0050_0093 in cycle 2.
REQ-039 Simultaneous requests: if_req=dm_req=1 held, with immediate acks -> grant order DM, DM, IF, DM, DM, IF; ready pulses never overlap.
REQ-040 Store: dm_req=1, dm_we=1, dm_addr=0x64, dm_wdata=0xDEAD_BEEF, ack after 3 wait cycles -> mem_we=1 and mem_wdata=0xDEADBEEF for 4 cycles; dm_ready pulses once; dm_rdata is unchanged.
REQ-041 Timeout: dm_req read with mem_ack held 0 -> mem_req drops after 16 BUSY cycles; dm_ready=1, bus_err=1, dm_rdata=0 for one cycle.
REQ-042 Reset mid-operation: reset=0 in the 2nd BUSY cycle -> mem_req=0 immediately and no ready pulse; after reset=1, a new if_req completes normally.
